// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with frame debounce and 4-key history.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_DOWN,
    output logic [3:0] NUM0,
    output logic [3:0] NUM1,
    output logic [3:0] NUM2,
    output logic [3:0] NUM3
);

    localparam int               c_div_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0]       c_deb_last = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    logic [3:0]         row_meta_q, row_sync_q;
    logic [c_div_w-1:0] div_q;
    logic [1:0]         col_q;
    logic [11:0]        acc_q;
    logic [15:0]        frame_q;
    logic               frame_done_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic       accept;
    logic       key_valid_q;
    logic [3:0] code_q, num0_q, num1_q, num2_q, num3_q;

    logic [4:0] act_cnt;
    logic [3:0] key_idx;
    logic [3:0] key_code;
    logic       is_none, is_single;

    // Bit index in the frame is col*4+row, so the map is read column by column.
    function automatic logic [3:0] keymap(input logic [3:0] idx);
        case (idx)
            4'd0:  keymap = 4'h1;  4'd1:  keymap = 4'h4;
            4'd2:  keymap = 4'h7;  4'd3:  keymap = 4'h0;
            4'd4:  keymap = 4'h2;  4'd5:  keymap = 4'h5;
            4'd6:  keymap = 4'h8;  4'd7:  keymap = 4'hF;
            4'd8:  keymap = 4'h3;  4'd9:  keymap = 4'h6;
            4'd10: keymap = 4'h9;  4'd11: keymap = 4'hE;
            4'd12: keymap = 4'hA;  4'd13: keymap = 4'hB;
            4'd14: keymap = 4'hC;  default: keymap = 4'hD;
        endcase
    endfunction

    // Rows are sampled at the last divider count so the column has settled.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            div_q        <= '0;
            col_q        <= 2'd0;
            acc_q        <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_meta_q   <= ROW;
            row_sync_q   <= row_meta_q;
            frame_done_q <= 1'b0;
            if (div_q == c_div_last) begin
                div_q <= '0;
                col_q <= col_q + 2'd1;
                if (col_q == 2'd3) begin
                    frame_q      <= {~row_sync_q, acc_q};
                    frame_done_q <= 1'b1;
                end else begin
                    acc_q[{col_q, 2'b00} +: 4] <= ~row_sync_q;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    always_comb begin
        act_cnt = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_q[i]) begin
                act_cnt = act_cnt + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign is_none   = (act_cnt == 5'd0);
    assign is_single = (act_cnt == 5'd1);
    assign key_code  = keymap(key_idx);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (frame_done_q) begin
            case (state_q)
                IDLE: begin
                    if (is_single) begin
                        cand_d  = key_code;
                        cnt_d   = 4'd1;
                        state_d = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (is_single && (key_code == cand_q)) begin
                        if (cnt_q + 4'd1 == c_deb_last) begin
                            cnt_d   = 4'd0;
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        cnt_d   = 4'd1;
                        state_d = DEB_REL;
                    end
                end
                default: begin
                    if (is_none) begin
                        if (cnt_q + 4'd1 == c_deb_last) begin
                            cnt_d   = 4'd0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_valid_q <= 1'b0;
            code_q      <= 4'd0;
            num0_q      <= 4'd0;
            num1_q      <= 4'd0;
            num2_q      <= 4'd0;
            num3_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= accept;
            if (accept) begin
                code_q <= cand_q;
                num3_q <= num2_q;
                num2_q <= num1_q;
                num1_q <= num0_q;
                num0_q <= cand_q;
            end
        end
    end

    assign COL       = ~(4'b0001 << col_q);
    assign KEY_CODE  = code_q;
    assign KEY_VALID = key_valid_q;
    assign KEY_DOWN  = (state_q == PRESSED) || (state_q == DEB_REL);
    assign NUM0      = num0_q;
    assign NUM1      = num1_q;
    assign NUM2      = num2_q;
    assign NUM3      = num3_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Scoreboard bench for keypad_scanner with a keypad matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    logic       CLK;
    logic       RESETN;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEY_CODE;
    logic       KEY_VALID;
    logic       KEY_DOWN;
    logic [3:0] NUM0, NUM1, NUM2, NUM3;

    logic [15:0] pressed;
    logic [15:0] hist;
    logic        prev_valid;
    int          vectors;
    int          miscompares;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] nums;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .ROW       (ROW),
        .COL       (COL),
        .KEY_CODE  (KEY_CODE),
        .KEY_VALID (KEY_VALID),
        .KEY_DOWN  (KEY_DOWN),
        .NUM0      (NUM0),
        .NUM1      (NUM1),
        .NUM2      (NUM2),
        .NUM3      (NUM3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pressed key at bit col*4+row pulls that row low while its column is driven.
    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!COL[c] && pressed[c*4+r]) ROW[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) @(negedge CLK);
    endtask

    // Consumes exactly one frame so scan alignment is kept.
    task automatic check_down(input string name, input logic exp);
        repeat (4) @(negedge CLK);
        chk(name, {31'd0, KEY_DOWN}, {31'd0, exp});
        repeat (12) @(negedge CLK);
    endtask

    task automatic expect_key(input logic [3:0] code);
        hist = {hist[11:0], code};
        exp_q.push_back({code, hist});
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_col"},  {28'd0, COL}, 32'hE);
        chk({name, "_outs"}, {12'd0, KEY_CODE, NUM3, NUM2, NUM1, NUM0},
            32'd0);
        chk({name, "_flags"}, {30'd0, KEY_VALID, KEY_DOWN}, 32'd0);
    endtask

    // Monitor: every accepted-key pulse is matched against the scoreboard.
    always @(negedge CLK) begin
        if (RESETN && KEY_VALID) begin
            if (prev_valid) chk("valid_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {28'd0, KEY_CODE}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("accepted_key", {12'd0, KEY_CODE, NUM3, NUM2, NUM1, NUM0},
                    {12'd0, e.code, e.nums});
            end
        end
        prev_valid = RESETN && KEY_VALID;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        pressed     = 16'd0;
        hist        = 16'd0;
        prev_valid  = 1'b0;
        RESETN      = 1'b0;

        repeat (3) @(negedge CLK);
        check_zero_outputs("reset");
        RESETN = 1'b1;

        // Idle scan: 5 frames, column walks E,D,B,7 every 4 clocks.
        for (int k = 0; k < 80; k++) begin
            chk("idle_col", {28'd0, COL}, {28'd0, ~(4'b0001 << ((k / 4) % 4))});
            chk("idle_flags", {30'd0, KEY_VALID, KEY_DOWN}, 32'd0);
            @(negedge CLK);
        end

        // Key 5 held, released 2 frames, re-pressed: one event only.
        expect_key(4'h5);
        pressed = 16'd1 << 5;
        frames(3);
        check_down("key5_down", 1'b1);
        pressed = 16'd0;
        frames(2);
        pressed = 16'd1 << 5;
        frames(1);
        check_down("key5_repress_down", 1'b1);
        pressed = 16'd0;
        frames(3);
        check_down("key5_released", 1'b0);

        // Bouncing key 9: 2 on, 1 off, 3 on.
        pressed = 16'd1 << 10;
        frames(2);
        pressed = 16'd0;
        frames(1);
        expect_key(4'h9);
        pressed = 16'd1 << 10;
        frames(3);
        check_down("key9_down", 1'b1);
        pressed = 16'd0;
        frames(3);
        check_down("key9_released", 1'b0);

        // Keys 1 and 2 together: never accepted.
        pressed = (16'd1 << 0) | (16'd1 << 4);
        frames(4);
        check_down("multi_idle", 1'b0);
        pressed = 16'd0;
        frames(3);
        chk("multi_code_held", {28'd0, KEY_CODE}, 32'h9);

        // Sequence A,3,0,F with full releases.
        expect_key(4'hA); pressed = 16'd1 << 12; frames(3);
        pressed = 16'd0; frames(4);
        expect_key(4'h3); pressed = 16'd1 << 8;  frames(3);
        pressed = 16'd0; frames(4);
        expect_key(4'h0); pressed = 16'd1 << 3;  frames(3);
        pressed = 16'd0; frames(4);
        expect_key(4'hF); pressed = 16'd1 << 7;  frames(3);
        pressed = 16'd0; frames(3);
        check_down("seq_released", 1'b0);
        chk("seq_history", {16'd0, NUM3, NUM2, NUM1, NUM0}, 32'hA30F);
        chk("seq_code", {28'd0, KEY_CODE}, 32'hF);

        // Reset during the 2nd debounce frame of key 7.
        pressed = 16'd1 << 2;
        frames(1);
        repeat (8) @(negedge CLK);
        RESETN = 1'b0;
        hist   = 16'd0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(negedge CLK);
        check_zero_outputs("midreset_hold");
        expect_key(4'h7);
        RESETN = 1'b1;
        frames(3);
        check_down("key7_down", 1'b1);
        pressed = 16'd0;
        frames(3);
        check_down("key7_released", 1'b0);

        frames(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
